// File: rtl/fmul_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fmul_arbiter_if : requester A/B handshakes plus the shared-multiplier bus
// Revision: 1.0
// ---------------------------------------------------------------------------
interface fmul_arbiter_if;
   logic        a_valid;
   logic        a_ready;
   logic [31:0] a_x1;
   logic [31:0] a_x2;
   logic        a_rvalid;
   logic        a_rready;
   logic [31:0] a_y;

   logic        b_valid;
   logic        b_ready;
   logic [31:0] b_x1;
   logic [31:0] b_x2;
   logic        b_rvalid;
   logic        b_rready;
   logic [31:0] b_y;

   logic [31:0] fmul_x1;
   logic [31:0] fmul_x2;
   logic [31:0] fmul_y;
   logic        busy;

   modport master (
      output a_valid, a_x1, a_x2, a_rready,
      input  a_ready, a_rvalid, a_y,
      output b_valid, b_x1, b_x2, b_rready,
      input  b_ready, b_rvalid, b_y,
      input  fmul_x1, fmul_x2, busy,
      output fmul_y
   );

   modport slave (
      input  a_valid, a_x1, a_x2, a_rready,
      output a_ready, a_rvalid, a_y,
      input  b_valid, b_x1, b_x2, b_rready,
      output b_ready, b_rvalid, b_y,
      output fmul_x1, fmul_x2, busy,
      input  fmul_y
   );
endinterface
`default_nettype wire

// File: rtl/fmul_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fmul_arbiter : round-robin sharing of one 1-cycle FP multiplier by two requesters
// Revision: 1.0
// ---------------------------------------------------------------------------
module fmul_arbiter (
   input  wire logic      clk,
   input  wire logic      rstn,
   fmul_arbiter_if.slave  bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] WB   = 2'd2;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   logic [1:0]  state;
   logic [1:0]  next_state;
   logic [31:0] op_x1;
   logic [31:0] op_x2;
   logic        owner;
   logic        last_grant;
   logic        a_full;
   logic        b_full;
   logic [31:0] a_buf;
   logic [31:0] b_buf;

   logic        sel_a;
   logic        sel_b;
   logic        accept;

   // Arbitration view: while rstn is low, decide as if the registers already held reset values.
   logic [1:0]  view_state;
   logic        view_a_full;
   logic        view_b_full;
   logic        view_last;
   logic        elig_a;
   logic        elig_b;
   logic        can_accept;

   always_comb begin
      view_state  = rstn ? state      : IDLE;
      view_a_full = rstn ? a_full     : 1'b0;
      view_b_full = rstn ? b_full     : 1'b0;
      view_last   = rstn ? last_grant : REQ_B;
      can_accept  = (view_state == IDLE) || (view_state == WB);
      elig_a      = !view_a_full && !((view_state != IDLE) && (owner == REQ_A));
      elig_b      = !view_b_full && !((view_state != IDLE) && (owner == REQ_B));
      sel_a       = can_accept && elig_a && bus.a_valid &&
                    (!(elig_b && bus.b_valid) || (view_last == REQ_B));
      sel_b       = can_accept && elig_b && bus.b_valid && !sel_a;
      accept      = sel_a || sel_b;
   end

   // State register together with the datapath registers it governs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         op_x1      <= 32'd0;
         op_x2      <= 32'd0;
         owner      <= REQ_A;
         last_grant <= REQ_B;
         a_full     <= 1'b0;
         b_full     <= 1'b0;
         a_buf      <= 32'd0;
         b_buf      <= 32'd0;
      end else begin
         state <= next_state;
         if (accept) begin
            op_x1      <= sel_b ? bus.b_x1 : bus.a_x1;
            op_x2      <= sel_b ? bus.b_x2 : bus.a_x2;
            owner      <= sel_b;
            last_grant <= sel_b;
         end
         if (a_full && bus.a_rready) a_full <= 1'b0;
         if (b_full && bus.b_rready) b_full <= 1'b0;
         // Write-back never targets a requester that is draining: the owner cannot hold a result.
         if (state == WB) begin
            if (owner == REQ_A) begin
               a_buf  <= bus.fmul_y;
               a_full <= 1'b1;
            end else begin
               b_buf  <= bus.fmul_y;
               b_full <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = accept ? MUL : IDLE;
         MUL:     next_state = WB;
         WB:      next_state = accept ? MUL : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.a_ready  = sel_a;
      bus.b_ready  = sel_b;
      bus.busy     = (state != IDLE);
      bus.fmul_x1  = op_x1;
      bus.fmul_x2  = op_x2;
      bus.a_rvalid = a_full;
      bus.b_rvalid = b_full;
      bus.a_y      = a_buf;
      bus.b_y      = b_buf;
   end

endmodule
`default_nettype wire

// File: tb/tb_fmul_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fmul_arbiter : directed self-checking bench with a lookup multiplier model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fmul_arbiter;

   logic clk;
   logic rstn;
   int   checks;
   int   errors;

   fmul_arbiter_if bus ();

   fmul_arbiter dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier stand-in: one-cycle registered product for the operand pairs used here.
   function automatic logic [31:0] mul_model(input logic [31:0] x1, input logic [31:0] x2);
      case ({x1, x2})
         {32'h3F800000, 32'h40000000}: mul_model = 32'h40000000;
         {32'hBF800000, 32'h3F800000}: mul_model = 32'hBF800000;
         {32'h00000000, 32'h40400000}: mul_model = 32'h00000000;
         {32'h40400000, 32'h40000000}: mul_model = 32'h40C00000;
         default:                      mul_model = 32'h7FC00000;
      endcase
   endfunction

   always_ff @(posedge clk) bus.fmul_y <= mul_model(bus.fmul_x1, bus.fmul_x2);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstn = 1'b0;
      bus.a_valid = 1'b0; bus.a_x1 = 32'd0; bus.a_x2 = 32'd0; bus.a_rready = 1'b0;
      bus.b_valid = 1'b0; bus.b_x1 = 32'd0; bus.b_x2 = 32'd0; bus.b_rready = 1'b0;
      tick();
      tick();
      check("rst_busy",     {31'd0, bus.busy},     32'd0);
      check("rst_a_rvalid", {31'd0, bus.a_rvalid}, 32'd0);
      check("rst_b_rvalid", {31'd0, bus.b_rvalid}, 32'd0);
      check("rst_a_y",      bus.a_y,               32'd0);
      check("rst_b_y",      bus.b_y,               32'd0);
      check("rst_fmul_x1",  bus.fmul_x1,           32'd0);

      // Tie during reset: A wins because last_grant resets to B.
      bus.a_valid = 1'b1; bus.a_x1 = 32'h3F800000; bus.a_x2 = 32'h40000000;
      bus.b_valid = 1'b1; bus.b_x1 = 32'hBF800000; bus.b_x2 = 32'h3F800000;
      #1;
      check("rst_tie_a_ready", {31'd0, bus.a_ready}, 32'd1);
      check("rst_tie_b_ready", {31'd0, bus.b_ready}, 32'd0);
      rstn = 1'b1;

      // T: first cycle after reset, A accepted.
      check("t0_a_ready", {31'd0, bus.a_ready}, 32'd1);
      check("t0_b_ready", {31'd0, bus.b_ready}, 32'd0);
      tick();
      bus.a_valid = 1'b0;
      // T+1: MUL
      check("t1_busy",    {31'd0, bus.busy},    32'd1);
      check("t1_a_ready", {31'd0, bus.a_ready}, 32'd0);
      check("t1_b_ready", {31'd0, bus.b_ready}, 32'd0);
      check("t1_fmul_x1", bus.fmul_x1, 32'h3F800000);
      check("t1_fmul_x2", bus.fmul_x2, 32'h40000000);
      tick();
      // T+2: WB, B accepted overlapping the write-back
      check("t2_busy",     {31'd0, bus.busy},     32'd1);
      check("t2_b_ready",  {31'd0, bus.b_ready},  32'd1);
      check("t2_a_rvalid", {31'd0, bus.a_rvalid}, 32'd0);
      tick();
      bus.b_valid = 1'b0;
      // T+3
      check("t3_a_rvalid", {31'd0, bus.a_rvalid}, 32'd1);
      check("t3_a_y",      bus.a_y, 32'h40000000);
      check("t3_busy",     {31'd0, bus.busy}, 32'd1);
      check("t3_fmul_x1",  bus.fmul_x1, 32'hBF800000);
      tick();
      check("t4_b_rvalid", {31'd0, bus.b_rvalid}, 32'd0);
      tick();
      // T+5: sign result for B
      check("t5_b_rvalid", {31'd0, bus.b_rvalid}, 32'd1);
      check("t5_b_y",      bus.b_y, 32'hBF800000);
      check("t5_busy",     {31'd0, bus.busy}, 32'd0);

      // Backpressure on A while B is drained and served again.
      bus.a_valid = 1'b1; bus.a_x1 = 32'h40400000; bus.a_x2 = 32'h40000000;
      bus.b_rready = 1'b1;
      #1;
      check("bp_a_ready0", {31'd0, bus.a_ready}, 32'd0);
      check("bp_b_ready0", {31'd0, bus.b_ready}, 32'd0);
      tick();
      bus.b_rready = 1'b0;
      bus.b_valid = 1'b1; bus.b_x1 = 32'h00000000; bus.b_x2 = 32'h40400000;
      #1;
      check("bp_b_rvalid_clr", {31'd0, bus.b_rvalid}, 32'd0);
      check("bp_b_ready1",     {31'd0, bus.b_ready},  32'd1);
      check("bp_a_ready1",     {31'd0, bus.a_ready},  32'd0);
      tick();
      bus.b_valid = 1'b0;
      tick();
      check("bp_wb_a_ready", {31'd0, bus.a_ready}, 32'd0);
      tick();
      check("zf_b_rvalid", {31'd0, bus.b_rvalid}, 32'd1);
      check("zf_b_y",      bus.b_y, 32'h00000000);
      check("bp_a_y_held", bus.a_y, 32'h40000000);
      bus.a_rready = 1'b1;
      #1;
      check("bp_drain_a_ready", {31'd0, bus.a_ready}, 32'd0);
      tick();
      bus.a_rready = 1'b0;
      #1;
      check("bp_a_rvalid_clr", {31'd0, bus.a_rvalid}, 32'd0);
      check("bp_a_ready_rise", {31'd0, bus.a_ready},  32'd1);
      tick();
      bus.a_valid = 1'b0;
      // In MUL: reset aborts the operation.
      check("ab_busy_mul", {31'd0, bus.busy}, 32'd1);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      check("ab_busy",     {31'd0, bus.busy},     32'd0);
      check("ab_b_rvalid", {31'd0, bus.b_rvalid}, 32'd0);
      check("ab_fmul_x1",  bus.fmul_x1, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ab_no_a_rvalid", {31'd0, bus.a_rvalid}, 32'd0);
      end

      // Single operation latency after recovery.
      bus.a_valid = 1'b1;
      #1;
      check("lat_a_ready", {31'd0, bus.a_ready}, 32'd1);
      tick();
      bus.a_valid = 1'b0;
      tick();
      check("lat_t2_a_rvalid", {31'd0, bus.a_rvalid}, 32'd0);
      tick();
      check("lat_t3_a_rvalid", {31'd0, bus.a_rvalid}, 32'd1);
      check("lat_t3_a_y",      bus.a_y, 32'h40C00000);
      check("lat_t3_busy",     {31'd0, bus.busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
